// File: rtl/vector_bist.sv
// Table-driven self-test sequencer: applies stored vectors to a gate block and checks the
// masked response. Each vector takes SETTLE+2 cycles; table writes while busy are dropped.
module vector_bist #(
    parameter int NIN    = 2,
    parameter int NOUT   = 1,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 1,
    parameter int ERRW   = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int VW    = NIN + 2 * NOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [VW-1:0]   wr_data,
    input  logic [AW:0]     num_vecs,
    input  logic            start,
    output logic [NIN-1:0]  dut_in,
    input  logic [NOUT-1:0] dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic [AW-1:0]   fail_index,
    output logic [NOUT-1:0] fail_got,
    output logic [NOUT-1:0] fail_exp
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SET_INIT = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [AW:0]   DEPTH_N  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    logic [VW-1:0]   mem [DEPTH];
    logic [AW-1:0]   idx;
    logic [AW:0]     n;
    logic [SW-1:0]   cnt;
    logic [AW:0]     n_req;
    logic [VW-1:0]   cur;
    logic [NIN-1:0]  cur_in;
    logic [NOUT-1:0] cur_exp;
    logic [NOUT-1:0] cur_care;
    logic            mismatch;
    logic            last_vec;

    // Table is deliberately outside the reset domain so vectors survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        n_req    = (num_vecs > DEPTH_N) ? DEPTH_N : num_vecs;
        cur      = mem[idx];
        cur_in   = cur[NIN-1:0];
        cur_exp  = cur[NIN +: NOUT];
        cur_care = cur[NIN+NOUT +: NOUT];
        mismatch = |((dut_out ^ cur_exp) & cur_care);
        last_vec = ({1'b0, idx} == (n - 1'b1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            n          <= '0;
            cnt        <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_index <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n          <= n_req;
                        idx        <= '0;
                        err_count  <= '0;
                        fail_index <= '0;
                        fail_got   <= '0;
                        fail_exp   <= '0;
                        if (n_req == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_APPLY;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end else if (state == S_DONE) begin
                        done <= 1'b1;
                        pass <= (err_count == '0);
                    end
                end
                S_APPLY: begin
                    dut_in <= cur_in;
                    cnt    <= SET_INIT;
                    state  <= (SETTLE > 0) ? S_SETTLE : S_CHECK;
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                        // A saturating counter never wraps, so zero means no earlier failure.
                        if (err_count == '0) begin
                            fail_index <= idx;
                            fail_got   <= dut_out;
                            fail_exp   <= cur_exp;
                        end
                    end
                    if (last_vec) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_bist.sv
// Scoreboard bench for vector_bist driving an and2 gate; second instance with ERRW=2 for saturation.
module tb_vector_bist;

    localparam int SET = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en0, wr_en2;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [4:0] num_vecs;
    logic       start0, start2;

    logic [1:0] din0, din2;
    logic       dout0, dout2;
    logic       busy0, done0, pass0, busy2, done2, pass2;
    logic [7:0] err0;
    logic [1:0] err2;
    logic [3:0] fidx0, fidx2;
    logic       fgot0, fexp0, fgot2, fexp2;

    assign dout0 = &din0;
    assign dout2 = &din2;

    always #5 clk = ~clk;

    vector_bist u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vecs(num_vecs), .start(start0), .dut_in(din0), .dut_out(dout0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_index(fidx0), .fail_got(fgot0), .fail_exp(fexp0)
    );

    vector_bist #(.ERRW(2)) u_dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vecs(num_vecs), .start(start2), .dut_in(din2), .dut_out(dout2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_index(fidx2), .fail_got(fgot2), .fail_exp(fexp2)
    );

    typedef struct {
        int err;
        int fidx;
        int fgot;
        int fexp;
        int pass;
    } res_t;

    res_t       res_q[$];
    logic [1:0] din_q[$];
    logic [3:0] tb_tab[16];
    logic [1:0] last_in[2];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tb_write(input int a, input logic c, input logic e, input logic [1:0] in);
        wr_addr = a[3:0];
        wr_data = {c, e, in};
        wr_en0  = 1'b1;
        wr_en2  = 1'b1;
        @(posedge clk); #1;
        wr_en0    = 1'b0;
        wr_en2    = 1'b0;
        tb_tab[a] = {c, e, in};
    endtask

    task automatic run_check(input string tag, input bit sel, input int nv,
                             input bit bw_en, input logic [3:0] bw_addr, input logic [3:0] bw_data);
        int         n, done_edge, maxerr, e;
        res_t       r;
        logic [1:0] rin;
        logic       g, ex, ca;
        maxerr = sel ? 3 : 255;
        n      = (nv > 16) ? 16 : nv;
        r      = '{0, 0, 0, 0, 0};
        for (int i = 0; i < n; i++) begin
            rin = tb_tab[i][1:0];
            ex  = tb_tab[i][2];
            ca  = tb_tab[i][3];
            g   = &rin;
            din_q.push_back(rin);
            if (((g ^ ex) & ca) == 1'b1) begin
                if (r.err == 0) begin
                    r.fidx = i;
                    r.fgot = int'(g);
                    r.fexp = int'(ex);
                end
                if (r.err < maxerr) r.err++;
            end
        end
        r.pass = (r.err == 0) ? 1 : 0;
        res_q.push_back(r);
        done_edge = (n == 0) ? 0 : n * (SET + 2) + 1;

        num_vecs = 5'(nv);
        if (sel) start2 = 1'b1;
        else     start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start2 = 1'b0;
        e = 0;
        while (e < done_edge) begin
            if (bw_en && e == 1) begin
                wr_addr = bw_addr;
                wr_data = bw_data;
                if (sel) wr_en2 = 1'b1;
                else     wr_en0 = 1'b1;
            end else begin
                wr_en0 = 1'b0;
                wr_en2 = 1'b0;
            end
            @(posedge clk); #1;
            e++;
            if (e == 1) chk({tag, "_busy"}, sel ? busy2 : busy0, 1);
            if (e <= n * (SET + 2) && (e - 1) % (SET + 2) == 0)
                chk({tag, "_dut_in"}, sel ? din2 : din0, din_q.pop_front());
            if (e == done_edge - 1) chk({tag, "_done_early"}, sel ? done2 : done0, 0);
        end
        wr_en0 = 1'b0;
        wr_en2 = 1'b0;
        if (n == 0) chk({tag, "_dut_in_held"}, sel ? din2 : din0, last_in[sel]);
        else        last_in[sel] = tb_tab[n-1][1:0];
        r = res_q.pop_front();
        chk({tag, "_done"}, sel ? done2 : done0, 1);
        chk({tag, "_pass"}, sel ? pass2 : pass0, r.pass);
        chk({tag, "_err"}, sel ? 32'(err2) : 32'(err0), r.err);
        chk({tag, "_fidx"}, sel ? fidx2 : fidx0, r.fidx);
        chk({tag, "_fgot"}, sel ? fgot2 : fgot0, r.fgot);
        chk({tag, "_fexp"}, sel ? fexp2 : fexp0, r.fexp);
    endtask

    task automatic load_and2(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            tb_write(i, 1'b1, (i % 4) == 3, 2'(i % 4));
        end
    endtask

    initial begin
        reset    = 1'b1;
        wr_en0   = 1'b0;
        wr_en2   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        num_vecs = '0;
        start0   = 1'b0;
        start2   = 1'b0;
        last_in[0] = 2'b00;
        last_in[1] = 2'b00;
        for (int i = 0; i < 16; i++) tb_tab[i] = 4'h0;
        #23;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_dut_in", din0, 0);
        chk("rst_err", err0, 0);
        chk("rst_fidx", fidx0, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        load_and2(4);
        run_check("truth", 0, 4, 0, '0, '0);

        tb_write(2, 1'b1, 1'b1, 2'b10);
        run_check("bad_exp", 0, 4, 0, '0, '0);

        tb_write(2, 1'b0, 1'b1, 2'b10);
        run_check("care0", 0, 4, 0, '0, '0);

        tb_write(2, 1'b1, 1'b0, 2'b10);
        run_check("busy_wr", 0, 4, 1, 4'd2, 4'b1110);
        run_check("rerun", 0, 4, 0, '0, '0);

        run_check("nv0", 0, 0, 0, '0, '0);

        load_and2(16);
        run_check("nv31", 0, 31, 0, '0, '0);

        for (int i = 0; i < 8; i++) begin
            tb_write(i, 1'b1, ((i % 4) == 3) ^ (i >= 2 && i <= 6), 2'(i % 4));
        end
        run_check("sat", 1, 8, 0, '0, '0);
        run_check("sat_again", 1, 8, 0, '0, '0);
        run_check("nosat", 0, 8, 0, '0, '0);

        // Vector 0 fails so err_count is nonzero when reset lands in SETTLE of vector 1.
        tb_write(0, 1'b1, 1'b1, 2'b00);
        num_vecs = 5'd4;
        start0   = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", busy0, 1);
        chk("mid_err", err0, 1);
        reset = 1'b1;
        #1;
        chk("arst_busy", busy0, 0);
        chk("arst_done", done0, 0);
        chk("arst_dut_in", din0, 0);
        chk("arst_err", err0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_in[0] = 2'b00;
        last_in[1] = 2'b00;
        run_check("after_rst", 0, 4, 0, '0, '0);

        chk("din_q_empty", din_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_bist.md
# vector_bist

Synthesizable, parametrised built-in self-test sequencer for small combinational gate blocks (inv, nand2, and2 and wider successors). It holds a loadable table of test vectors, drives each input pattern onto a device under test, waits a settle interval, and compares the DUT response against the expected value under a per-bit care mask. It accumulates a saturating error count and captures the first failure. It sits beside the gate library so the library can be checked on hardware without a simulator testbench.

## Interface
- NIN, 2, DUT input width (≥1)
- NOUT, 1, DUT output width (≥1)
- DEPTH, 16, vector table entries (≥2); AW = $clog2(DEPTH)
- SETTLE, 1, wait cycles between applying a vector and sampling the response (≥0)
- ERRW, 8, error counter width
- Vector entry layout, VW = NIN+2*NOUT bits: {care[NOUT], exp[NOUT], in[NIN]}, MSB first
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address
- wr_data  in  VW  table write data
- num_vecs  in  AW+1  vectors to run; sampled on start; values >DEPTH clamp to DEPTH
- start  in  1  begin run; accepted in IDLE or DONE only
- dut_in  out  NIN  registered stimulus to DUT
- dut_out  in  NOUT  DUT response
- busy  out  1  run in progress
- done  out  1  run complete (level, held in DONE)
- pass  out  1  done and err_count==0
- err_count  out  ERRW  mismatching vectors, saturating at all-ones
- fail_index  out  AW  index of first failing vector
- fail_got  out  NOUT  dut_out at first failure
- fail_exp  out  NOUT  exp at first failure

## Operation
- Table: register array, combinational read. Write when wr_en && !busy; writes while busy are ignored. Table contents are not cleared by reset.
- FSM states:
  - IDLE: start → latch n = min(num_vecs, DEPTH), idx=0, clear err_count and fail_*. Go to DONE if n==0, else APPLY.
  - APPLY (1 cycle): dut_in <= table[idx].in. Go to SETTLE if SETTLE>0, else CHECK.
  - SETTLE (SETTLE cycles, down-counter): then CHECK.
  - CHECK (1 cycle): mismatch = |((dut_out ^ exp) & care). On mismatch, err_count increments unless it is saturated. On the first mismatch of the run, capture fail_index=idx, fail_got=dut_out, fail_exp=exp. If idx==n-1, go to DONE; else idx++ and go to APPLY.
  - DONE: done=1, pass=(err_count==0). start → same behaviour as start in IDLE. Results hold until the next accepted start.
- busy=1 in APPLY, SETTLE and CHECK. start while busy is ignored.
- A care bit of 0 makes that output bit don't-care. care of all zeros never fails.
- fail_* is meaningful only when err_count≠0. It holds 0 otherwise.

## Timing
- Reset values:
  - State IDLE.
  - dut_in, err_count, fail_index, fail_got, fail_exp = 0.
  - busy, done, pass = 0.
- Each vector takes SETTLE+2 cycles. start is sampled at edge 0. done rises at edge n*(SETTLE+2)+1.
- n==0: done=1 and pass=1 after the edge that accepts start.
- dut_in changes only on the edge leaving APPLY. It holds its value through SETTLE, CHECK and DONE.
- dut_out is sampled only on the edge ending CHECK, so the DUT may have up to SETTLE+1 cycles of combinational delay.
- Reset asserted mid-run: immediate return to IDLE with all outputs at their reset values. The table is retained.
- Saturation: once err_count reaches 2^ERRW−1, further mismatches leave it unchanged.

## Test plan
- Default params, DUT=and2, table loaded with the truth table {in=00,exp=0}, {01,0}, {10,0}, {11,1}, care=1, num_vecs=4, start → done at edge 13; pass=1, err_count=0; dut_in steps 00, 01, 10, 11.
- Same setup with entry 2 changed to exp=1 → err_count=1, fail_index=2, fail_got=0, fail_exp=1, pass=0.
- Entry 2 with exp=1 and care=0 → pass=1. Separately, writing to the table while busy leaves the table unchanged; checked by rerunning with the bad entry restored.
- num_vecs=0 → done=1 and pass=1 one edge after start, with no change on dut_in. num_vecs=31 with DEPTH=16 → 16 vectors run, done at edge 49.
- ERRW=2, 5 failing vectors → err_count=3 (saturated), fail_index=first failing index. start in DONE → counters clear and the run repeats identically.
- reset asserted during SETTLE of vector 1 → busy, done, dut_in and err_count read 0 immediately. A following start runs from idx 0 using the retained table.
